// File: rtl/multi_pulse_generator.sv
// Multi-channel programmable pulse generator. One shared period counter drives CHANNELS
// pulse outputs, each with its own width and phase, from double-buffered configuration.
module multi_pulse_generator #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      oneshot,
  input  logic                      cfg_load,
  input  logic [CNT_W-1:0]          cfg_period,
  input  logic [CHANNELS*CNT_W-1:0] cfg_width,
  input  logic [CHANNELS*CNT_W-1:0] cfg_phase,
  output logic [CHANNELS-1:0]       pulse,
  output logic                      period_start,
  output logic                      busy,
  output logic                      done
);

  localparam int                 CW         = CHANNELS * CNT_W;
  localparam logic [CNT_W-1:0]   MIN_PERIOD = CNT_W'(2);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                mode_os, mode_os_n;
  logic                rearm, rearm_n;
  logic [CNT_W-1:0]    shd_period, act_period, act_period_n;
  logic [CW-1:0]       shd_width, shd_phase;
  logic [CW-1:0]       act_width, act_width_n, act_phase, act_phase_n;
  logic [CNT_W-1:0]    eff_p, eff_p_n;
  logic [CNT_W:0]      c_x, p_x, ph_x, w_x, d;
  logic                run_n, load_act;
  logic [CHANNELS-1:0] pulse_n;
  logic                period_start_n, busy_n, done_n;

  assign eff_p = (act_period < MIN_PERIOD) ? MIN_PERIOD : act_period;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    mode_os_n      = mode_os;
    rearm_n        = rearm;
    load_act       = 1'b0;
    run_n          = 1'b0;
    done_n         = 1'b0;

    case (state)
      IDLE: begin
        // After a one-shot, enable must be seen low before another start is accepted.
        if (!enable) begin
          rearm_n = 1'b0;
        end else if (!rearm) begin
          state_n   = RUN;
          cnt_n     = '0;
          mode_os_n = oneshot;
          load_act  = 1'b1;
          run_n     = 1'b1;
        end
      end
      RUN: begin
        if (cnt != eff_p - CNT_W'(1)) begin
          cnt_n = cnt + CNT_W'(1);
          run_n = 1'b1;
        end else if (!mode_os && enable) begin
          cnt_n    = '0;
          load_act = 1'b1;
          run_n    = 1'b1;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = mode_os;
          rearm_n = mode_os;
        end
      end
      default: state_n = IDLE;
    endcase

    // A load coinciding with a start or wrap bypasses the shadow registers.
    act_period_n = act_period;
    act_width_n  = act_width;
    act_phase_n  = act_phase;
    if (load_act) begin
      act_period_n = cfg_load ? cfg_period : shd_period;
      act_width_n  = cfg_load ? cfg_width  : shd_width;
      act_phase_n  = cfg_load ? cfg_phase  : shd_phase;
    end

    eff_p_n = (act_period_n < MIN_PERIOD) ? MIN_PERIOD : act_period_n;
    p_x     = {1'b0, eff_p_n};
    c_x     = {1'b0, cnt_n};
    ph_x    = '0;
    w_x     = '0;
    d       = '0;
    pulse_n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ph_x       = {1'b0, act_phase_n[i*CNT_W +: CNT_W]};
      w_x        = {1'b0, act_width_n[i*CNT_W +: CNT_W]};
      d          = (c_x >= ph_x) ? (c_x - ph_x) : (c_x + p_x - ph_x);
      pulse_n[i] = run_n && (ph_x < p_x) && (d < w_x);
    end

    period_start_n = run_n && (cnt_n == '0);
    busy_n         = run_n;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      mode_os      <= 1'b0;
      rearm        <= 1'b0;
      shd_period   <= MIN_PERIOD;
      shd_width    <= '0;
      shd_phase    <= '0;
      act_period   <= MIN_PERIOD;
      act_width    <= '0;
      act_phase    <= '0;
      pulse        <= '0;
      period_start <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      mode_os      <= mode_os_n;
      rearm        <= rearm_n;
      act_period   <= act_period_n;
      act_width    <= act_width_n;
      act_phase    <= act_phase_n;
      pulse        <= pulse_n;
      period_start <= period_start_n;
      busy         <= busy_n;
      done         <= done_n;
      if (cfg_load) begin
        shd_period <= cfg_period;
        shd_width  <= cfg_width;
        shd_phase  <= cfg_phase;
      end
    end
  end

endmodule
